aes_key_expand_seq: RTL and testbench

//  Sequential AES key expander, the parametrised successor to the single-round combinational key step.

---
 rtl/aes_key_expand_seq.sv | 219 +++++++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128/192/256 key expander, one schedule word per cycle, round keys streamed out.
// Optional KEYEXP_STORE_EN keeps every accepted round key in a readable register file.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign s_o = affine(gf_inv(a_i));

endmodule

module aes_key_expand_seq #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [3:0]          rk_round,
  output logic [127:0]        rk_data,
  output logic                done,
  input  logic [3:0]          rd_idx,
  output logic [127:0]        rd_key
);

  localparam int         NK   = KEY_BITS / 32;
  localparam int         NR   = NK + 6;
  localparam logic [3:0] NR_W = 4'(NR);
  localparam logic [5:0] NK_W = 6'(NK);
  localparam logic [2:0] NK_M = 3'(NK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;

  state_e         state_q, state_d;
  logic [31:0]    win_q [NK];
  logic [31:0]    win_d [NK];
  logic [5:0]     i_q, i_d;
  logic [2:0]     j_q, j_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           rk_valid_q, rk_valid_d;
  logic [3:0]     rk_round_q, rk_round_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic           done_q, done_d;
  logic           write_en;
  logic [31:0]    prev_w, sbox_in, sub_w, new_w;

  // win_q[0] is w[i-Nk], win_q[NK-1] is w[i-1]; the key words rotate through during i<Nk.
  assign prev_w  = win_q[NK-1];
  assign sbox_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i(sbox_in[8*g +: 8]),
      .s_o(sub_w[8*g +: 8])
    );
  end

  always_comb begin
    new_w = win_q[0] ^ prev_w;
    if (i_q < NK_W) begin
      new_w = win_q[0];
    end else if (j_q == 3'd0) begin
      new_w = win_q[0] ^ sub_w ^ {rcon_q, 24'h000000};
    end else if ((NK == 8) && (j_q == 3'd4)) begin
      new_w = win_q[0] ^ sub_w;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    i_d        = i_q;
    j_d        = j_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    rk_round_d = rk_round_q;
    rk_data_d  = rk_data_q;
    done_d     = 1'b0;
    write_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          for (int k = 0; k < NK; k++) begin
            win_d[k] = key_in[KEY_BITS-1-32*k -: 32];
          end
          i_d        = 6'd0;
          j_d        = 3'd0;
          rcon_d     = 8'h01;
          rk_valid_d = 1'b0;
        end
      end
      ST_RUN: write_en = 1'b1;
      ST_HOLD: begin
        if (rk_ready) begin
          rk_valid_d = 1'b0;
          if (rk_round_q == NR_W) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_RUN;
            write_en = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (write_en) begin
      for (int k = 0; k < NK - 1; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[NK-1] = new_w;
      rk_data_d   = {rk_data_q[95:0], new_w};
      i_d         = i_q + 6'd1;
      j_d         = (j_q == NK_M) ? 3'd0 : j_q + 3'd1;
      if (i_q >= NK_W && j_q == 3'd0) begin
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
      if (i_q[1:0] == 2'd3) begin
        rk_valid_d = 1'b1;
        rk_round_d = i_q[5:2];
        state_d    = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int k = 0; k < NK; k++) win_q[k] <= 32'h0;
      i_q        <= 6'd0;
      j_q        <= 3'd0;
      rcon_q     <= 8'h00;
      rk_valid_q <= 1'b0;
      rk_round_q <= 4'd0;
      rk_data_q  <= 128'h0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      rk_round_q <= rk_round_d;
      rk_data_q  <= rk_data_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign rk_valid = rk_valid_q;
  assign rk_round = rk_round_q;
  assign rk_data  = rk_data_q;
  assign done     = done_q;

`ifdef KEYEXP_STORE_EN
  logic [127:0] store_q [NR+1];
  logic [127:0] rd_key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NR; k++) store_q[k] <= 128'h0;
      rd_key_q <= 128'h0;
    end else begin
      if (state_q == ST_HOLD && rk_ready) store_q[rk_round_q] <= rk_data_q;
      rd_key_q <= (rd_idx <= NR_W) ? store_q[rd_idx] : 128'h0;
    end
  end

  assign rd_key = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - directed-vector bench for aes_key_expand_seq (128/192/256 instances).

module tb_aes_key_expand_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start_v;
  logic [2:0]   ready_v;
  logic [2:0]   busy_v, valid_v, done_v;
  logic [3:0]   round_v [3];
  logic [127:0] data_v  [3];
  logic [127:0] rdkey_v [3];
  logic [3:0]   rd_idx;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;

  aes_key_expand_seq #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key128), .busy(busy_v[0]),
    .rk_valid(valid_v[0]), .rk_ready(ready_v[0]), .rk_round(round_v[0]), .rk_data(data_v[0]),
    .done(done_v[0]), .rd_idx(rd_idx), .rd_key(rdkey_v[0])
  );

  aes_key_expand_seq #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key192), .busy(busy_v[1]),
    .rk_valid(valid_v[1]), .rk_ready(ready_v[1]), .rk_round(round_v[1]), .rk_data(data_v[1]),
    .done(done_v[1]), .rd_idx(rd_idx), .rd_key(rdkey_v[1])
  );

  aes_key_expand_seq #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key256), .busy(busy_v[2]),
    .rk_valid(valid_v[2]), .rk_ready(ready_v[2]), .rk_round(round_v[2]), .rk_data(data_v[2]),
    .done(done_v[2]), .rd_idx(rd_idx), .rd_key(rdkey_v[2])
  );

  localparam logic [127:0] KEY_A128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] exp128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [127:0] got_key [16];
  int           last_valid_edge, done_edge, nkeys;
  logic         done_busy, done_after;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Edge E0 is the start edge; e counts edges after it. A round key is logged when accepted.
  task automatic run_expand(input int sel, input int stall_round, input int stall_cycles, input int inj_edge);
    int stall_left;
    stall_left      = stall_cycles;
    last_valid_edge = -1;
    done_edge       = -1;
    nkeys           = 0;
    done_busy       = 1'b1;
    done_after      = 1'b1;
    for (int k = 0; k < 16; k++) got_key[k] = 128'h0;
    ready_v[sel] = 1'b1;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    for (int e = 1; e <= 200 && done_edge < 0; e++) begin
      @(posedge clk); #1;
      if (e == inj_edge - 1) begin
        start_v[sel] = 1'b1;
        key128       = KEY_ALT;
      end
      if (e == inj_edge) start_v[sel] = 1'b0;
      if (done_v[sel]) begin
        done_edge = e;
        done_busy = busy_v[sel];
      end
      if (valid_v[sel]) begin
        if (int'(round_v[sel]) == stall_round && stall_left > 0) begin
          ready_v[sel] = 1'b0;
          stall_left--;
          check("stall_data", data_v[sel], exp128[3]);
          check("stall_round", 128'(round_v[sel]), 128'd3);
        end else begin
          ready_v[sel] = 1'b1;
          got_key[round_v[sel]] = data_v[sel];
          last_valid_edge = e;
          nkeys++;
        end
      end
    end
    @(posedge clk); #1;
    done_after = done_v[sel];
    ready_v[sel] = 1'b1;
  endtask

  task automatic check_aes128(input string tag, input int exp_last, input int exp_done);
    for (int r = 0; r < 11; r++) check($sformatf("%s_rk%0d", tag, r), got_key[r], exp128[r]);
    check({tag, "_nkeys"}, 128'(nkeys), 128'd11);
    check({tag, "_last_edge"}, 128'(last_valid_edge), 128'(exp_last));
    check({tag, "_done_edge"}, 128'(done_edge), 128'(exp_done));
    check({tag, "_busy_at_done"}, 128'(done_busy), 128'd0);
    check({tag, "_done_pulse"}, 128'(done_after), 128'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start_v = 3'b000;
    ready_v = 3'b111;
    rd_idx  = 4'd0;
    key128  = KEY_A128;
    key192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_busy%0d", d), 128'(busy_v[d]), 128'd0);
      check($sformatf("rst_valid%0d", d), 128'(valid_v[d]), 128'd0);
      check($sformatf("rst_round%0d", d), 128'(round_v[d]), 128'd0);
      check($sformatf("rst_data%0d", d), data_v[d], 128'h0);
      check($sformatf("rst_done%0d", d), 128'(done_v[d]), 128'd0);
      check($sformatf("rst_rdkey%0d", d), rdkey_v[d], 128'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run_expand(0, -1, 0, 0);
    check_aes128("t1", 44, 45);

    rd_idx = 4'd10;
    @(posedge clk); #1;
`ifdef KEYEXP_STORE_EN
    check("t6_rd10", rdkey_v[0], exp128[10]);
`else
    check("t6_rd10", rdkey_v[0], 128'h0);
`endif
    rd_idx = 4'd15;
    @(posedge clk); #1;
    check("t6_rd15", rdkey_v[0], 128'h0);
    rd_idx = 4'd0;
    @(posedge clk); #1;
`ifdef KEYEXP_STORE_EN
    check("t6_rd0", rdkey_v[0], exp128[0]);
`else
    check("t6_rd0", rdkey_v[0], 128'h0);
`endif

    run_expand(1, -1, 0, 0);
    check("t2_rk0", got_key[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    check("t2_rk12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
    check("t2_nkeys", 128'(nkeys), 128'd13);
    check("t2_last_edge", 128'(last_valid_edge), 128'd52);
    check("t2_done_edge", 128'(done_edge), 128'd53);

    run_expand(2, -1, 0, 0);
    check("t3_rk0", got_key[0], 128'h603deb1015ca71be2b73aef0857d7781);
    check("t3_rk1", got_key[1], 128'h1f352c073b6108d72d9810a30914dff4);
    check("t3_rk14", got_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
    check("t3_nkeys", 128'(nkeys), 128'd15);
    check("t3_last_edge", 128'(last_valid_edge), 128'd60);
    check("t3_done_edge", 128'(done_edge), 128'd61);

    run_expand(0, 3, 5, 0);
    check_aes128("t4", 49, 50);

    run_expand(0, -1, 0, 10);
    key128 = KEY_A128;
    check_aes128("t5_inj", 44, 45);

    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("t5_busy_pre_rst", 128'(busy_v[0]), 128'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 128'(busy_v[0]), 128'd0);
    check("t5_rst_valid", 128'(valid_v[0]), 128'd0);
    check("t5_rst_round", 128'(round_v[0]), 128'd0);
    check("t5_rst_data", data_v[0], 128'h0);
    check("t5_rst_done", 128'(done_v[0]), 128'd0);
    check("t5_rst_rdkey", rdkey_v[0], 128'h0);
    @(posedge clk); #1;
    check("t5_rst_no_done", 128'(done_v[0]), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_expand(0, -1, 0, 0);
    check_aes128("t5_fresh", 44, 45);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
